// File: rtl/regb_fifo_serializer_pkg.sv
// regb_ser_pkg: shared types for the FIFO drain serializer.
// State encoding, default sizes and counter-width helpers.
package regb_ser_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } ser_state_e;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_STOP_BITS    = 1;

    // A 1-clock bit still needs a 1-bit counter.
    function automatic int baud_cnt_w(input int cpb);
        return (cpb <= 1) ? 1 : $clog2(cpb);
    endfunction

    // Holds 0..WIDTH (one spare bit over $clog2).
    function automatic int bit_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DEF_BAUD_CNT_W = baud_cnt_w(DEF_CLKS_PER_BIT);
    localparam int DEF_BIT_CNT_W  = bit_cnt_w(DEF_WIDTH);

endpackage

// File: rtl/regb_fifo_serializer_if.sv
// regb_fifo_serializer_if: FIFO head / pop handshake.
// master = FIFO (drives head), slave = serializer (drives pop).
interface regb_fifo_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_empty_n;
    logic             fifo_shift_out;

    modport master (
        output fifo_data,
        output fifo_empty_n,
        input  fifo_shift_out
    );

    modport slave (
        input  fifo_data,
        input  fifo_empty_n,
        output fifo_shift_out
    );
endinterface

// File: rtl/regb_fifo_serializer_baud_tick.sv
// regb_ser_baud_tick: 0..CLKS_PER_BIT-1 bit-period counter.
// Ports: clk, res_n, clr (sync clear), cnt, tick (last clock of bit).
module regb_ser_baud_tick
    import regb_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    localparam int CW = baud_cnt_w(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regb_fifo_serializer.sv
// regb_fifo_serializer: pops FIFO head words and sends them LSB-first
// as UART frames. Ports: clk, res_n, fifo (slave: fifo_data,
// fifo_empty_n in / fifo_shift_out out), tx, busy, frame_done.
// Optional even-parity bit after data: define REGB_SER_PARITY_EN.
module regb_fifo_serializer
    import regb_ser_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic clk,
    input  logic res_n,
    regb_fifo_serializer_if.slave fifo,
    output logic tx,
    output logic busy,
    output logic frame_done
);

    localparam int CW = baud_cnt_w(CLKS_PER_BIT);
    localparam int BW = bit_cnt_w(WIDTH);

    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    ser_state_e       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shr;
    logic [BW-1:0]    bitcnt;
    logic [CW-1:0]    cnt;
    logic             tick;

    logic start_end;
    logic data_end;
    logic stop_end;
    logic enter_stop;
    logic state_chg;
    logic cap_go;
    logic fd_next;

`ifdef REGB_SER_PARITY_EN
    logic par_bit;
    logic par_end;
`endif

    assign shr = shreg >> 1;

    assign start_end = (state == S_START) && tick;
    assign data_end  = (state == S_DATA) && tick
                       && (bitcnt == LAST_BIT);
    assign stop_end  = (state == S_STOP) && tick
                       && (bitcnt == LAST_STOP);

`ifdef REGB_SER_PARITY_EN
    assign par_end    = (state == S_PARITY) && tick;
    assign enter_stop = par_end;
    assign state_chg  = start_end | data_end | par_end | stop_end;
`else
    assign enter_stop = data_end;
    assign state_chg  = start_end | data_end | stop_end;
`endif

    // Pop from IDLE, or chain straight off the last stop clock.
    assign cap_go = fifo.fifo_empty_n
                    && ((state == S_IDLE) || stop_end);

    regb_ser_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .res_n (res_n),
        .clr   ((state == S_IDLE) || state_chg),
        .cnt   (cnt),
        .tick  (tick)
    );

    // frame_done is registered, so predict whether the next
    // clock is the final clock of the stop period.
    always_comb begin
        fd_next = 1'b0;
        if (enter_stop) begin
            fd_next = (CLKS_PER_BIT == 1) && (STOP_BITS == 1);
        end else if ((state == S_STOP) && !stop_end) begin
            if (tick) begin
                fd_next = (CLKS_PER_BIT == 1)
                          && (bitcnt + 1'b1 == LAST_STOP);
            end else begin
                fd_next = (int'(cnt) + 1 == CLKS_PER_BIT - 1)
                          && (bitcnt == LAST_STOP);
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state          <= S_IDLE;
            shreg          <= '0;
            bitcnt         <= '0;
            tx             <= 1'b1;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            fifo.fifo_shift_out <= 1'b0;
`ifdef REGB_SER_PARITY_EN
            par_bit        <= 1'b0;
`endif
        end else begin
            fifo.fifo_shift_out <= 1'b0;
            frame_done     <= fd_next;
            if (cap_go) begin
                state  <= S_START;
                shreg  <= fifo.fifo_data;
                bitcnt <= '0;
                tx     <= 1'b0;
                busy   <= 1'b1;
                fifo.fifo_shift_out <= 1'b1;
`ifdef REGB_SER_PARITY_EN
                par_bit <= ^fifo.fifo_data;
`endif
            end else begin
                unique case (state)
                    S_IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    S_START: begin
                        if (tick) begin
                            state  <= S_DATA;
                            tx     <= shreg[0];
                            bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        if (tick) begin
                            shreg <= shr;
                            if (bitcnt == LAST_BIT) begin
                                bitcnt <= '0;
`ifdef REGB_SER_PARITY_EN
                                state  <= S_PARITY;
                                tx     <= par_bit;
`else
                                state  <= S_STOP;
                                tx     <= 1'b1;
`endif
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                                tx     <= shr[0];
                            end
                        end
                    end
`ifdef REGB_SER_PARITY_EN
                    S_PARITY: begin
                        if (tick) begin
                            state  <= S_STOP;
                            tx     <= 1'b1;
                            bitcnt <= '0;
                        end
                    end
`endif
                    S_STOP: begin
                        if (tick) begin
                            if (bitcnt == LAST_STOP) begin
                                state  <= S_IDLE;
                                busy   <= 1'b0;
                                tx     <= 1'b1;
                                bitcnt <= '0;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regb_fifo_serializer.sv
// tb_regb_fifo_serializer: FIFO model + UART frame scoreboard.
// Expected words are queued at push; a line monitor decodes frames.
module tb_regb_fifo_serializer;

    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef REGB_SER_PARITY_EN
    localparam int PB      = 1;
    localparam int EXP_LEN = 44;
`else
    localparam int PB      = 0;
    localparam int EXP_LEN = 40;
`endif
    localparam int FLEN = (1 + W + PB + SB) * CPB;

    typedef struct {
        logic [W-1:0] d;
        logic         p;
    } exp_t;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic tx;
    logic busy;
    logic frame_done;

    regb_fifo_serializer_if #(.WIDTH(W)) fif ();

    regb_fifo_serializer #(
        .WIDTH        (W),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .fifo       (fif.slave),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t         expq[$];
    logic [W-1:0] fq[$];
    int           pops = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic p);
        exp_t e;
        e.d = d;
        e.p = p;
        fq.push_back(d);
        expq.push_back(e);
    endtask

    // FIFO model: pops on the edge after a registered pop strobe.
    always @(posedge clk) begin
        if (fif.fifo_shift_out === 1'b1) begin
            pops++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        fif.fifo_empty_n <= (fq.size() != 0);
        fif.fifo_data    <= (fq.size() != 0) ? fq[0] : '0;
    end

    // Line monitor
    logic [FLEN-1:0] txh;
    logic [FLEN-1:0] fdh;
    int cyc = 0;
    bit in_frame = 0;
    int gap = 0;
    int last_gap = -1;
    int run = 0;
    int last_run = 0;
    int stray = 0;
    int frames = 0;

    task automatic end_frame();
        logic [FLEN-1:0] ev;
        logic [FLEN-1:0] fdev;
        logic [W-1:0]    dec;
        exp_t            e;
        int              s;
        frames++;
        check("frame_expected", 64'(expq.size() != 0), 64'd1);
        if (expq.size() == 0) return;
        e = expq.pop_front();
        for (int i = 0; i < FLEN; i++) begin
            s = i / CPB;
            if (s == 0) ev[i] = 1'b0;
            else if (s <= W) ev[i] = e.d[s-1];
            else if (PB == 1 && s == W + 1) ev[i] = e.p;
            else ev[i] = 1'b1;
        end
        check("tx_frame", 64'(txh), 64'(ev));
        for (int b = 0; b < W; b++)
            dec[b] = txh[(1 + b) * CPB + CPB / 2];
        check("byte", 64'(dec), 64'(e.d));
`ifdef REGB_SER_PARITY_EN
        check("parity", 64'(txh[(1 + W) * CPB + CPB / 2]),
              64'(e.p));
`endif
        fdev = '0;
        fdev[FLEN-1] = 1'b1;
        check("frame_done_pos", 64'(fdh), 64'(fdev));
    endtask

    always @(negedge clk) begin
        if (!res_n) begin
            in_frame = 0;
            cyc = 0;
            run = 0;
        end else begin
            if (busy === 1'b1) begin
                run++;
            end else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            if (!in_frame) begin
                if (frame_done !== 1'b0) stray++;
                if (tx === 1'b0) begin
                    in_frame = 1;
                    last_gap = gap;
                    txh = '0;
                    fdh = '0;
                    txh[0] = tx;
                    fdh[0] = frame_done;
                    cyc = 1;
                end else begin
                    gap++;
                end
            end else begin
                txh[cyc] = tx;
                fdh[cyc] = frame_done;
                cyc++;
            end
            if (in_frame && cyc == FLEN) begin
                end_frame();
                in_frame = 0;
                gap = 0;
            end
        end
    end

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((busy !== 1'b0 || fq.size() != 0
                || expq.size() != 0 || in_frame) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 64'(n < bound), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int p0;
        int f0;
        int n;

        // 1: reset hold with a valid head word, then release
        res_n = 1'b0;
        push(8'hA5, 1'b0);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0
                || fif.fifo_shift_out !== 1'b0) viol++;
        end
        check("rst_hold", 64'(viol), 64'd0);
        check("rst_pops", 64'(pops), 64'd0);
        res_n = 1'b1;
        @(posedge clk);
        #1;
        check("cap_pop", 64'(fif.fifo_shift_out), 64'd1);
        check("cap_tx", 64'(tx), 64'd0);
        check("cap_busy", 64'(busy), 64'd1);
        wait_idle("t1", 300);

        // 2: single word 0x01
        p0 = pops;
        push(8'h01, 1'b1);
        wait_idle("t2", 300);
        check("t2_pops", 64'(pops - p0), 64'd1);
        check("t2_busy_len", 64'(last_run), 64'(EXP_LEN));

        // 3: back-to-back 0x10, 0x20
        p0 = pops;
        push(8'h10, 1'b1);
        push(8'h20, 1'b1);
        wait_idle("t3", 400);
        check("t3_pops", 64'(pops - p0), 64'd2);
        check("t3_gap", 64'(last_gap), 64'd0);
        check("t3_busy_len", 64'(last_run), 64'(2 * EXP_LEN));

        // 4: empty FIFO
        p0 = pops;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("t4_idle", 64'(viol), 64'd0);
        check("t4_pops", 64'(pops - p0), 64'd0);

        // 5: reset during data bit 3 of 0xFF
        push(8'hFF, 1'b0);
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_start", 64'(busy), 64'd1);
        repeat (17) @(negedge clk);
        check("t5_bit3_tx", 64'(tx), 64'd1);
        #1;
        res_n = 1'b0;
        #1;
        check("t5_async_tx", 64'(tx), 64'd1);
        check("t5_async_busy", 64'(busy), 64'd0);
        expq.delete();
        f0 = frames;
        repeat (3) @(negedge clk);
        res_n = 1'b1;
        viol = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0
                || frame_done !== 1'b0) viol++;
        end
        check("t5_idle", 64'(viol), 64'd0);
        check("t5_frames", 64'(frames - f0), 64'd0);

`ifdef REGB_SER_PARITY_EN
        // 6: parity frames
        push(8'h07, 1'b1);
        push(8'h03, 1'b0);
        wait_idle("t6", 400);
        check("t6_busy_len", 64'(last_run), 64'd88);
`endif

        check("stray_frame_done", 64'(stray), 64'd0);
        check("exp_empty", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
